// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: program counter, single-outstanding imem read, decode handoff
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] target;

  assign target     = {redirect_pc[31:2], 2'b00};
  assign imem_req   = (state == S_REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state == S_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC_W;
      kill     <= 1'b0;
      inst     <= 32'd0;
      inst_pc  <= 32'd0;
      misalign <= 1'b0;
    end else begin
      // Redirect wins over stall and data capture; the capture branch below excludes it.
      if (redirect && (state != S_IDLE)) begin
        pc <= target;
        if (redirect_pc[1:0] != 2'b00) misalign <= 1'b1;
      end
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            state <= S_WAIT;
            kill  <= redirect;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            kill  <= 1'b0;
            state <= S_REQ;
            if (!kill && !redirect) begin
              inst    <= imem_rdata;
              inst_pc <= pc;
              pc      <= pc + 32'd4;
              state   <= S_OUT;
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        S_OUT: begin
          if (redirect || !stall) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
